// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types for the multi-channel PWM block (counting modes,
// counter direction) plus a small decode helper for the raw mode field.
package pwm_pkg;

  // Counting modes; the reserved encoding behaves exactly like PWM_UP.
  typedef enum logic [1:0] {
    PWM_UP   = 2'd0,
    PWM_DOWN = 2'd1,
    PWM_UPDN = 2'd2,
    PWM_RSVD = 2'd3
  } pwm_mode_t;

  // Direction of the shared counter; only meaningful in PWM_UPDN.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_t;

  // Decode the two-bit mode request into the enum type.
  function automatic pwm_mode_t to_mode(input logic [1:0] raw);
    return pwm_mode_t'(raw);
  endfunction

endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: shared counter for all PWM channels. Produces the counter
// value, tracks the up/down direction for centre-aligned mode and flags the
// period boundary cycle. When the owner reloads the active set on a boundary
// (xfer), the next counter value is taken from the incoming set so the new
// period starts cleanly.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk50m,
  input  logic         rst,
  input  logic         en,
  input  pwm_mode_t    mode_a,
  input  logic [W-1:0] per_a,
  input  logic         xfer,
  input  pwm_mode_t    mode_s,
  input  logic [W-1:0] per_s,
  output logic [W-1:0] cnt,
  output logic         bnd
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};

  pwm_dir_t     dir;
  pwm_dir_t     dir_nxt;
  logic [W-1:0] cnt_nxt;
  logic [W-1:0] top_a;   // last count value of the active period (P-1)
  logic [W-1:0] top_s;   // last count value of the staged period

  // Top-of-count for active and staged periods; a zero period acts as one.
  always_comb begin
    if (per_a == ZERO) begin
      top_a = ZERO;
    end else begin
      top_a = per_a - ONE;
    end
    if (per_s == ZERO) begin
      top_s = ZERO;
    end else begin
      top_s = per_s - ONE;
    end
  end

  // Boundary detect for the currently active mode.
  always_comb begin
    bnd = 1'b0;
    case (mode_a)
      PWM_DOWN: bnd = (cnt == ZERO);
      PWM_UPDN: bnd = (top_a == ZERO) || ((dir == DIR_DOWN) && (cnt == ZERO));
      default:  bnd = (cnt >= top_a);
    endcase
  end

  // Next counter value and direction.
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (xfer) begin
      // Reload from the staged set: start of the incoming mode's period.
      case (mode_s)
        PWM_DOWN: begin
          cnt_nxt = top_s;
          dir_nxt = DIR_UP;
        end
        PWM_UPDN: begin
          // Staying centre-aligned continues with the rising edge from 0;
          // entering it from another mode restarts at 0.
          if ((mode_a == PWM_UPDN) && (top_s != ZERO)) begin
            cnt_nxt = ONE;
          end else begin
            cnt_nxt = ZERO;
          end
          dir_nxt = DIR_UP;
        end
        default: begin
          cnt_nxt = ZERO;
          dir_nxt = DIR_UP;
        end
      endcase
    end else if (cnt > top_a) begin
      // Counter outside the period: restart as the active mode's start value.
      if (mode_a == PWM_DOWN) begin
        cnt_nxt = top_a;
      end else begin
        cnt_nxt = ZERO;
      end
      dir_nxt = DIR_UP;
    end else begin
      case (mode_a)
        PWM_DOWN: begin
          if (bnd) begin
            cnt_nxt = top_a;
          end else begin
            cnt_nxt = cnt - ONE;
          end
          dir_nxt = DIR_UP;
        end
        PWM_UPDN: begin
          if (top_a == ZERO) begin
            cnt_nxt = ZERO;
            dir_nxt = DIR_UP;
          end else if (dir == DIR_UP) begin
            if (cnt == top_a) begin
              cnt_nxt = cnt - ONE;
              dir_nxt = DIR_DOWN;
            end else begin
              cnt_nxt = cnt + ONE;
              dir_nxt = DIR_UP;
            end
          end else begin
            if (cnt == ZERO) begin
              cnt_nxt = ONE;
              dir_nxt = DIR_UP;
            end else begin
              cnt_nxt = cnt - ONE;
              dir_nxt = DIR_DOWN;
            end
          end
        end
        default: begin
          if (bnd) begin
            cnt_nxt = ZERO;
          end else begin
            cnt_nxt = cnt + ONE;
          end
          dir_nxt = DIR_UP;
        end
      endcase
    end
  end

  // Counter and direction registers; frozen while en is low.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      cnt <= ZERO;
      dir <= DIR_UP;
    end else if (en) begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: N PWM channels sharing one timebase. Requests are captured into
// a staging set by upd and become active only on a period boundary, so every
// period runs with a consistent mode, period and compare set.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int W = 16,
  parameter int N = 4
) (
  input  logic           clk50m,
  input  logic           rst,
  input  logic           en,
  input  logic [1:0]     mode,
  input  logic [W-1:0]   per,
  input  logic [N*W-1:0] cmp,
  input  logic           upd,
  output logic [W-1:0]   cnt,
  output logic [N-1:0]   pwm,
  output logic           prd_evt,
  output logic           upd_pend
);

  localparam logic [W-1:0] ZERO = {W{1'b0}};

  pwm_mode_t    mode_s;
  pwm_mode_t    mode_a;
  logic [W-1:0] per_s;
  logic [W-1:0] per_a;
  logic         bnd;
  logic         xfer;

  // Staging moves to active only on an enabled boundary with something pending.
  assign xfer = en & bnd & upd_pend;

  pwm_timebase #(
    .W(W)
  ) u_timebase (
    .clk50m (clk50m),
    .rst    (rst),
    .en     (en),
    .mode_a (mode_a),
    .per_a  (per_a),
    .xfer   (xfer),
    .mode_s (mode_s),
    .per_s  (per_s),
    .cnt    (cnt),
    .bnd    (bnd)
  );

  // Shared staging/active mode and period, pending flag and period event.
  // A transfer and a new capture on the same edge: the transfer takes the
  // old staging values and the pending flag stays set for the new ones.
  always_ff @(posedge clk50m or posedge rst) begin
    if (rst) begin
      mode_s   <= PWM_UP;
      per_s    <= ZERO;
      mode_a   <= PWM_UP;
      per_a    <= ZERO;
      upd_pend <= 1'b0;
      prd_evt  <= 1'b0;
    end else begin
      if (upd) begin
        mode_s <= to_mode(mode);
        per_s  <= per;
      end
      if (xfer) begin
        mode_a <= mode_s;
        per_a  <= per_s;
      end
      if (upd) begin
        upd_pend <= 1'b1;
      end else if (xfer) begin
        upd_pend <= 1'b0;
      end
      prd_evt <= en & bnd;
    end
  end

  // Per-channel compare staging, active compare and registered output.
  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [W-1:0] cmp_s;
    logic [W-1:0] cmp_a;
    logic         pwm_q;

    // Compare registers follow the same capture/transfer rules as the period;
    // the output is high while the counter is below the active compare.
    always_ff @(posedge clk50m or posedge rst) begin
      if (rst) begin
        cmp_s <= ZERO;
        cmp_a <= ZERO;
        pwm_q <= 1'b0;
      end else begin
        if (upd) begin
          cmp_s <= cmp[i*W +: W];
        end
        if (xfer) begin
          cmp_a <= cmp_s;
        end
        if (en) begin
          pwm_q <= (cnt < cmp_a);
        end
      end
    end

    assign pwm[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: directed scenarios with hand-computed expectations plus a
// randomized run, all checked every cycle against a phase-based model.
module tb_pwm_multi;

  logic        clk50m = 1'b0;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [7:0]  per;
  logic [15:0] cmp;
  logic        upd;
  logic [7:0]  cnt;
  logic [1:0]  pwm;
  logic        prd_evt;
  logic        upd_pend;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b1;

  // Reference model state: staging/active sets and a phase index inside
  // the current period from which the count value is derived.
  int m_mode_s, m_per_s, m_mode_a, m_per_a, m_k;
  int m_cmp_s[2];
  int m_cmp_a[2];
  bit m_pend;
  int e_cnt;
  bit [1:0] e_pwm;
  bit e_evt;

  int exp_dn[6]  = '{4, 3, 2, 1, 0, 4};
  int exp_ud[10] = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};

  pwm_multi #(.W(8), .N(2)) dut (
    .clk50m   (clk50m),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .per      (per),
    .cmp      (cmp),
    .upd      (upd),
    .cnt      (cnt),
    .pwm      (pwm),
    .prd_evt  (prd_evt),
    .upd_pend (upd_pend)
  );

  always #5 clk50m = ~clk50m;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  // Count value at phase k: UP walks 0..P-1, DOWN walks P-1..0, UPDN walks
  // a triangle 0..P-1..0 whose final 0 (phase 2(P-1)) ends the period.
  function automatic int model_cnt(input int md, input int p, input int k);
    if (md == 1) return p - 1 - k;
    if (md == 2) begin
      if (p == 1) return 0;
      if (k <= p - 1) return k;
      return 2 * (p - 1) - k;
    end
    return k;
  endfunction

  function automatic bit model_bnd(input int md, input int p, input int k);
    if (md == 2) return (p == 1) || (k == 2 * (p - 1));
    return k == p - 1;
  endfunction

  function automatic int model_next_k(input int md, input int p, input int k);
    if (md == 2) begin
      if (p == 1) return 0;
      return (k == 2 * (p - 1)) ? 1 : k + 1;
    end
    return (k + 1) % p;
  endfunction

  task automatic model_reset();
    m_mode_s = 0; m_per_s = 0; m_mode_a = 0; m_per_a = 0; m_k = 0;
    m_cmp_s[0] = 0; m_cmp_s[1] = 0; m_cmp_a[0] = 0; m_cmp_a[1] = 0;
    m_pend = 1'b0;
    e_cnt = 0; e_pwm = 2'b00; e_evt = 1'b0;
  endtask

  task automatic model_step();
    int p, pn, nk, c;
    bit b, xf;
    p  = eff(m_per_a);
    b  = model_bnd(m_mode_a, p, m_k);
    xf = 1'b0;
    if (en) begin
      c = model_cnt(m_mode_a, p, m_k);
      for (int i = 0; i < 2; i++) e_pwm[i] = (c < m_cmp_a[i]);
      e_evt = b;
      xf = b && m_pend;
      if (xf) begin
        pn = eff(m_per_s);
        nk = (m_mode_s == 2 && m_mode_a == 2 && pn > 1) ? 1 : 0;
        m_mode_a = m_mode_s;
        m_per_a  = m_per_s;
        m_cmp_a  = m_cmp_s;
      end else begin
        nk = model_next_k(m_mode_a, p, m_k);
      end
      m_k = nk;
    end else begin
      e_evt = 1'b0;
    end
    if (upd) begin
      m_pend     = 1'b1;
      m_mode_s   = int'(mode);
      m_per_s    = int'(per);
      m_cmp_s[0] = int'(cmp[7:0]);
      m_cmp_s[1] = int'(cmp[15:8]);
    end else if (xf) begin
      m_pend = 1'b0;
    end
    e_cnt = model_cnt(m_mode_a, eff(m_per_a), m_k);
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk50m) begin
    if (chk_on) begin
      chk("model_cnt", 32'(cnt), 32'(e_cnt));
      chk("model_pwm", 32'(pwm), 32'(e_pwm));
      chk("model_prd_evt", 32'(prd_evt), 32'(e_evt));
      chk("model_upd_pend", 32'(upd_pend), 32'(m_pend));
    end
  end

  task automatic tick();
    @(posedge clk50m);
    if (rst) model_reset();
    else model_step();
    @(negedge clk50m);
    #1;
  endtask

  task automatic pulse_upd();
    upd = 1'b1;
    tick();
    upd = 1'b0;
  endtask

  task automatic wait_pend_clear(input int max_cyc);
    int n;
    n = 0;
    while (upd_pend === 1'b1 && n < max_cyc) begin
      tick();
      n++;
    end
    chk("pend_clear_timeout", 32'(upd_pend), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    int h0, h1, ev;
    model_reset();
    rst = 1'b1; en = 1'b0; mode = 2'd0; per = 8'd0; cmp = 16'd0; upd = 1'b0;
    repeat (2) tick();
    chk("reset_cnt", 32'(cnt), 32'd0);
    chk("reset_pwm", 32'(pwm), 32'd0);
    chk("reset_evt", 32'(prd_evt), 32'd0);
    chk("reset_pend", 32'(upd_pend), 32'd0);
    rst = 1'b0; en = 1'b1;
    tick();
    chk("p1_cnt", 32'(cnt), 32'd0);
    chk("p1_evt", 32'(prd_evt), 32'd1);

    // UP, period 10, compares 3 and 7.
    mode = 2'd0; per = 8'd10; cmp = {8'd7, 8'd3};
    pulse_upd();
    chk("up_pend_set", 32'(upd_pend), 32'd1);
    wait_pend_clear(20);
    chk("up_first_cnt", 32'(cnt), 32'd0);
    repeat (10) tick();
    h0 = 0; h1 = 0; ev = 0;
    for (int j = 0; j < 20; j++) begin
      chk("up_seq", 32'(cnt), 32'(j % 10));
      h0 += int'(pwm[0]); h1 += int'(pwm[1]); ev += int'(prd_evt);
      tick();
    end
    chk("up_pwm0_high", 32'(h0), 32'd6);
    chk("up_pwm1_high", 32'(h1), 32'd14);
    chk("up_evt_count", 32'(ev), 32'd2);

    // DOWN, period 5.
    mode = 2'd1; per = 8'd5;
    pulse_upd();
    wait_pend_clear(20);
    for (int j = 0; j < 6; j++) begin
      chk("dn_seq", 32'(cnt), 32'(exp_dn[j]));
      chk("dn_evt", 32'(prd_evt), (j == 0 || j == 5) ? 32'd1 : 32'd0);
      tick();
    end

    // UPDN, period 5, compare 2: low values 1,0,1 of every 8 are below 2.
    mode = 2'd2; per = 8'd5; cmp = {8'd5, 8'd2};
    pulse_upd();
    wait_pend_clear(20);
    for (int j = 0; j < 10; j++) begin
      chk("ud_seq", 32'(cnt), 32'(exp_ud[j]));
      tick();
    end
    h0 = 0; ev = 0;
    for (int j = 0; j < 8; j++) begin
      h0 += int'(pwm[0]); ev += int'(prd_evt);
      tick();
    end
    chk("ud_pwm0_high", 32'(h0), 32'd3);
    chk("ud_evt_count", 32'(ev), 32'd1);

    // Mid-period period change, then an update on the boundary cycle.
    mode = 2'd0; per = 8'd10;
    pulse_upd();
    wait_pend_clear(20);
    chk("mid_start", 32'(cnt), 32'd0);
    repeat (4) tick();
    per = 8'd6;
    pulse_upd();
    chk("mid_cnt5", 32'(cnt), 32'd5);
    chk("mid_pend", 32'(upd_pend), 32'd1);
    repeat (4) tick();
    chk("mid_cnt9", 32'(cnt), 32'd9);
    chk("mid_pend9", 32'(upd_pend), 32'd1);
    tick();
    chk("mid_wrap", 32'(cnt), 32'd0);
    chk("mid_pend_clr", 32'(upd_pend), 32'd0);
    repeat (2) tick();
    per = 8'd8;
    pulse_upd();
    repeat (2) tick();
    chk("p6_top", 32'(cnt), 32'd5);
    per = 8'd4;
    pulse_upd();
    chk("bnd_upd_cnt", 32'(cnt), 32'd0);
    chk("bnd_upd_pend", 32'(upd_pend), 32'd1);
    repeat (7) tick();
    chk("p8_top", 32'(cnt), 32'd7);
    chk("p8_pend", 32'(upd_pend), 32'd1);
    tick();
    chk("p4_start", 32'(cnt), 32'd0);
    chk("p4_pend", 32'(upd_pend), 32'd0);
    repeat (3) tick();
    chk("p4_top", 32'(cnt), 32'd3);
    tick();
    chk("p4_wrap", 32'(cnt), 32'd0);

    // Compare 0 and 255 give constant outputs; period 0 behaves as 1.
    per = 8'd10; cmp = {8'd255, 8'd0};
    pulse_upd();
    wait_pend_clear(20);
    repeat (2) tick();
    for (int j = 0; j < 15; j++) begin
      chk("const_pwm", 32'(pwm), 32'd2);
      tick();
    end
    per = 8'd0;
    pulse_upd();
    wait_pend_clear(20);
    tick();
    for (int j = 0; j < 5; j++) begin
      chk("p0_cnt", 32'(cnt), 32'd0);
      chk("p0_evt", 32'(prd_evt), 32'd1);
      tick();
    end

    // Reset mid-count with an update pending.
    per = 8'd10;
    pulse_upd();
    wait_pend_clear(20);
    repeat (3) tick();
    mode = 2'd1; per = 8'd4;
    pulse_upd();
    chk("rst_pend_before", 32'(upd_pend), 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_async_cnt", 32'(cnt), 32'd0);
    chk("rst_async_pwm", 32'(pwm), 32'd0);
    chk("rst_async_evt", 32'(prd_evt), 32'd0);
    chk("rst_async_pend", 32'(upd_pend), 32'd0);
    tick();
    rst = 1'b0; mode = 2'd0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("post_rst_cnt", 32'(cnt), 32'd0);
      chk("post_rst_pend", 32'(upd_pend), 32'd0);
      chk("post_rst_evt", 32'(prd_evt), 32'd1);
    end

    // Randomized run checked by the every-cycle model comparison.
    for (int c = 0; c < 3000; c++) begin
      en   = ($urandom_range(0, 9) != 0);
      upd  = ($urandom_range(0, 11) == 0);
      mode = 2'($urandom_range(0, 3));
      per  = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255))
                                         : 8'($urandom_range(0, 12));
      cmp[7:0]  = ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 14));
      cmp[15:8] = 8'($urandom_range(0, 14));
      if ($urandom_range(0, 199) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      tick();
      rst = 1'b0;
    end
    upd = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
